// File: rtl/bus_dma_arbiter_if.sv
// Bus bundle between the RAM arbiter and its CPU, DMA-channel and RAM neighbours.
// The slave modport is the arbiter's view; master is the surrounding system.
interface bus_dma_arbiter_if #(
    parameter int unsigned NCHAN  = 4,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);
    logic                      bus_arbitrate;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [DATA_W-1:0]         cpu_data;
    logic                      cpu_rd;
    logic                      cpu_wr;
    logic                      cpu_byte_op;
    logic                      bus_ack;
    logic [NCHAN-1:0]          dma_req;
    logic [NCHAN-1:0]          dma_ack;
    logic [NCHAN-1:0]          dma_rd;
    logic [NCHAN-1:0]          dma_wr;
    logic [NCHAN*ADDR_W-1:0]   dma_addr;
    logic [NCHAN*DATA_W-1:0]   dma_data;
    logic [15:0]               ram_addr;
    logic [DATA_W-1:0]         ram_data_in;
    logic                      ram_ce_n;
    logic                      ram_we_n;
    logic                      ram_byte_op;

    modport slave (
        input  bus_arbitrate, cpu_addr, cpu_data, cpu_rd, cpu_wr, cpu_byte_op,
        input  dma_req, dma_rd, dma_wr, dma_addr, dma_data,
        output bus_ack, dma_ack, ram_addr, ram_data_in, ram_ce_n, ram_we_n, ram_byte_op
    );

    modport master (
        output bus_arbitrate, cpu_addr, cpu_data, cpu_rd, cpu_wr, cpu_byte_op,
        output dma_req, dma_rd, dma_wr, dma_addr, dma_data,
        input  bus_ack, dma_ack, ram_addr, ram_data_in, ram_ce_n, ram_we_n, ram_byte_op
    );
endinterface

// File: rtl/bus_dma_arbiter.sv
// RAM port arbiter: CPU owns the port by default; DMA channels win it round-robin
// for bounded bursts, and every grant returns through a one-cycle turnaround.
module bus_dma_arbiter #(
    parameter int unsigned NCHAN  = 4,
    parameter int unsigned BURST  = 4,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bus_dma_arbiter_if.slave     bus
);
    localparam int unsigned CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned BW     = 4;
    localparam int unsigned RAM_AW = 16;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(BURST);
    localparam logic [CW-1:0] CHAN_LAST = CW'(NCHAN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DMA  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cur_q,   cur_d;
    logic [CW-1:0]   last_q,  last_d;
    logic [BW-1:0]   beat_q,  beat_d;

    logic [CW-1:0]     pick_c;
    logic              sel_req_c;
    logic              sel_rd_c;
    logic              sel_wr_c;
    logic              sel_beat_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;

    // Next channel after last: lowest requester above last, else lowest overall.
    always_comb begin
        logic [CW-1:0] hi_pick;
        logic [CW-1:0] lo_pick;
        logic          hi_any;
        hi_pick = '0;
        lo_pick = '0;
        hi_any  = 1'b0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (bus.dma_req[i]) begin
                lo_pick = CW'(i);
                if (CW'(i) > last_q) begin
                    hi_pick = CW'(i);
                    hi_any  = 1'b1;
                end
            end
        end
        pick_c = hi_any ? hi_pick : lo_pick;
    end

    // Signals of the channel currently selected by cur.
    always_comb begin
        sel_req_c  = 1'b0;
        sel_rd_c   = 1'b0;
        sel_wr_c   = 1'b0;
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (cur_q == CW'(i)) begin
                sel_req_c  = bus.dma_req[i];
                sel_rd_c   = bus.dma_rd[i];
                sel_wr_c   = bus.dma_wr[i];
                sel_addr_c = bus.dma_addr[i*ADDR_W +: ADDR_W];
                sel_data_c = bus.dma_data[i*DATA_W +: DATA_W];
            end
        end
        sel_beat_c = sel_rd_c | sel_wr_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= CHAN_LAST;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        last_d          = last_q;
        beat_d          = beat_q;
        bus.bus_ack     = 1'b0;
        bus.dma_ack     = '0;
        bus.ram_addr    = bus.cpu_addr[RAM_AW-1:0];
        bus.ram_data_in = bus.cpu_data;
        bus.ram_ce_n    = 1'b1;
        bus.ram_we_n    = 1'b1;
        bus.ram_byte_op = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.bus_ack     = 1'b1;
                bus.ram_ce_n    = ~(bus.cpu_rd | bus.cpu_wr);
                bus.ram_we_n    = ~bus.cpu_wr;
                bus.ram_byte_op = bus.cpu_byte_op;
                if (bus.bus_arbitrate && (|bus.dma_req)) begin
                    state_d = ST_DMA;
                    cur_d   = pick_c;
                    last_d  = pick_c;
                    beat_d  = '0;
                end
            end
            ST_DMA: begin
                bus.dma_ack     = NCHAN'(1) << cur_q;
                bus.ram_addr    = sel_addr_c[RAM_AW-1:0];
                bus.ram_data_in = sel_data_c;
                bus.ram_ce_n    = ~sel_beat_c;
                bus.ram_we_n    = ~sel_wr_c;
                if (sel_beat_c && (beat_q != BEAT_MAX)) begin
                    beat_d = beat_q + BW'(1);
                end
                // Final beat and a dropped request both end the grant in one step.
                if ((sel_beat_c && (beat_q == BEAT_LAST)) || !sel_req_c) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep RAM deselected while reset is held, whatever the CPU drives.
        if (!reset_n) begin
            bus.ram_ce_n = 1'b1;
            bus.ram_we_n = 1'b1;
        end
    end

    if (ADDR_W > RAM_AW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^{bus.cpu_addr[ADDR_W-1:RAM_AW], sel_addr_c[ADDR_W-1:RAM_AW]};
    end
endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed self-checking bench for bus_dma_arbiter: reset, bursts, round-robin,
// early release, CPU pass-through and isolation of non-granted channels.
module tb_bus_dma_arbiter;
    localparam int unsigned NCHAN  = 4;
    localparam int unsigned BURST  = 4;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_dma_arbiter_if #(.NCHAN(NCHAN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    bus_dma_arbiter #(
        .NCHAN (NCHAN),
        .BURST (BURST),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    // {bus_ack, dma_ack[3:0], ram_ce_n, ram_we_n}
    logic [6:0] got7;
    logic [7:0] got8;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus_if.bus_arbitrate = 1'b0;
        bus_if.cpu_addr      = '0;
        bus_if.cpu_data      = '0;
        bus_if.cpu_rd        = 1'b0;
        bus_if.cpu_wr        = 1'b0;
        bus_if.cpu_byte_op   = 1'b0;
        bus_if.dma_req       = '0;
        bus_if.dma_rd        = '0;
        bus_if.dma_wr        = '0;
        bus_if.dma_addr      = {18'h0_3FF0, 18'h3_2C2C, 18'h2_1234, 18'h1_0A00};
        bus_if.dma_data      = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b1_0000_11) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", got7, 7'b1_0000_11);
        end
        bus_if.dma_req = 4'b0001;
        bus_if.bus_arbitrate = 1'b1;
        tick();
        checks++;
        if (bus_if.dma_ack !== 4'b0000 || bus_if.bus_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_holds_idle: got ack=%b bus_ack=%b expected 0000/1", bus_if.dma_ack, bus_if.bus_ack);
        end
        bus_if.dma_req = 4'b0000;
        bus_if.bus_arbitrate = 1'b0;
        reset_n = 1'b1;
        tick();
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b1_0000_11) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", got7, 7'b1_0000_11);
        end
    endtask

    task automatic test_burst();
        bus_if.dma_req = 4'b0010;
        bus_if.dma_rd = 4'b0010;
        bus_if.bus_arbitrate = 1'b1;
        #1;
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b1_0000) begin
            errors++;
            $display("FAIL burst_cpu_keeps_request_cycle: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b1_0000);
        end
        tick();
        bus_if.bus_arbitrate = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
            checks++;
            if (got7 !== 7'b0_0010_01) begin
                errors++;
                $display("FAIL burst_beat%0d_ctrl: got %b expected %b", k, got7, 7'b0_0010_01);
            end
            checks++;
            if (bus_if.ram_addr !== 16'h1234) begin
                errors++;
                $display("FAIL burst_beat%0d_addr: got %h expected %h", k, bus_if.ram_addr, 16'h1234);
            end
            tick();
        end
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b0_0000_11) begin
            errors++;
            $display("FAIL burst_turn: got %b expected %b", got7, 7'b0_0000_11);
        end
        tick();
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b1_0000_11) begin
            errors++;
            $display("FAIL burst_back_to_cpu: got %b expected %b", got7, 7'b1_0000_11);
        end
        bus_if.dma_req = 4'b0000;
        bus_if.dma_rd = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        bus_if.dma_req = 4'b0100;
        bus_if.dma_rd = 4'b0100;
        bus_if.bus_arbitrate = 1'b1;
        tick();
        bus_if.bus_arbitrate = 1'b0;
        #1;
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b0_0100) begin
            errors++;
            $display("FAIL midreset_granted: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b0_0100);
        end
        #2;
        reset_n = 1'b0;
        #1;
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b1_0000_11) begin
            errors++;
            $display("FAIL midreset_async: got %b expected %b", got7, 7'b1_0000_11);
        end
        tick();
        bus_if.dma_req = 4'b0000;
        bus_if.dma_rd = 4'b0000;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_ack;
        bus_if.dma_req = 4'b1111;
        bus_if.dma_rd = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_ack = 4'(1 << order[g]);
            bus_if.bus_arbitrate = 1'b1;
            #1;
            checks++;
            if (bus_if.bus_ack !== 1'b1) begin
                errors++;
                $display("FAIL rr%0d_idle_bus_ack: got %b expected 1", g, bus_if.bus_ack);
            end
            tick();
            bus_if.bus_arbitrate = 1'b0;
            #1;
            checks++;
            if ({bus_if.bus_ack, bus_if.dma_ack} !== {1'b0, exp_ack}) begin
                errors++;
                $display("FAIL rr%0d_grant: got %b expected %b", g, {bus_if.bus_ack, bus_if.dma_ack}, {1'b0, exp_ack});
            end
            repeat (4) tick();
            checks++;
            if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b0_0000) begin
                errors++;
                $display("FAIL rr%0d_turn: got %b expected %b", g, {bus_if.bus_ack, bus_if.dma_ack}, 5'b0_0000);
            end
            tick();
        end
        bus_if.dma_req = 4'b0000;
        bus_if.dma_rd = 4'b0000;
        tick();
    endtask

    task automatic test_short_grant();
        logic beat;
        bus_if.dma_req = 4'b0100;
        bus_if.bus_arbitrate = 1'b1;
        tick();
        bus_if.bus_arbitrate = 1'b0;
        for (int k = 0; k < 6; k++) begin
            beat = (k == 1) || (k == 4);
            bus_if.dma_rd = beat ? 4'b0100 : 4'b0000;
            bus_if.dma_req = (k == 5) ? 4'b0000 : 4'b0100;
            #1;
            checks++;
            if ({bus_if.dma_ack, bus_if.ram_ce_n} !== {4'b0100, ~beat}) begin
                errors++;
                $display("FAIL short_cycle%0d: got %b expected %b", k, {bus_if.dma_ack, bus_if.ram_ce_n}, {4'b0100, ~beat});
            end
            tick();
        end
        bus_if.dma_rd = 4'b0000;
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b0_0000) begin
            errors++;
            $display("FAIL short_turn: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b0_0000);
        end
        tick();
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b1_0000) begin
            errors++;
            $display("FAIL short_idle: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b1_0000);
        end
    endtask

    task automatic test_cpu_passthrough();
        bus_if.bus_arbitrate = 1'b0;
        bus_if.dma_req = 4'b1111;
        bus_if.cpu_addr = 18'h3_ABCD;
        bus_if.cpu_data = 16'h5A5A;
        bus_if.cpu_wr = 1'b1;
        bus_if.cpu_byte_op = 1'b1;
        #1;
        got8 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n, bus_if.ram_byte_op};
        checks++;
        if (got8 !== 8'b1_0000_001) begin
            errors++;
            $display("FAIL cpu_write_ctrl: got %b expected %b", got8, 8'b1_0000_001);
        end
        checks++;
        if ({bus_if.ram_addr, bus_if.ram_data_in} !== {16'hABCD, 16'h5A5A}) begin
            errors++;
            $display("FAIL cpu_write_bus: got %h expected %h", {bus_if.ram_addr, bus_if.ram_data_in}, {16'hABCD, 16'h5A5A});
        end
        tick();
        bus_if.cpu_wr = 1'b0;
        bus_if.cpu_rd = 1'b1;
        bus_if.cpu_byte_op = 1'b0;
        bus_if.cpu_addr = 18'h0_0042;
        #1;
        got8 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n, bus_if.ram_byte_op};
        checks++;
        if (got8 !== 8'b1_0000_010 || bus_if.ram_addr !== 16'h0042) begin
            errors++;
            $display("FAIL cpu_read: got %b addr %h expected %b addr 0042", got8, bus_if.ram_addr, 8'b1_0000_010);
        end
        tick();
        bus_if.cpu_rd = 1'b0;
        #1;
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b1_0000_11) begin
            errors++;
            $display("FAIL cpu_no_grant_without_arbitrate: got %b expected %b", got7, 7'b1_0000_11);
        end
        bus_if.dma_req = 4'b0000;
        tick();
    endtask

    task automatic test_ignore_other_strobes();
        bus_if.dma_req = 4'b0001;
        bus_if.dma_wr = 4'b1000;
        bus_if.bus_arbitrate = 1'b1;
        tick();
        bus_if.bus_arbitrate = 1'b0;
        #1;
        got8 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n, bus_if.ram_byte_op};
        checks++;
        if (got8 !== 8'b0_0001_110) begin
            errors++;
            $display("FAIL iso_ch3_write_ignored: got %b expected %b", got8, 8'b0_0001_110);
        end
        tick();
        bus_if.dma_wr = 4'b1001;
        #1;
        got8 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n, bus_if.ram_byte_op};
        checks++;
        if (got8 !== 8'b0_0001_000) begin
            errors++;
            $display("FAIL iso_ch0_write: got %b expected %b", got8, 8'b0_0001_000);
        end
        checks++;
        if ({bus_if.ram_addr, bus_if.ram_data_in} !== {16'h0A00, 16'hD000}) begin
            errors++;
            $display("FAIL iso_ch0_bus: got %h expected %h", {bus_if.ram_addr, bus_if.ram_data_in}, {16'h0A00, 16'hD000});
        end
        tick();
        bus_if.dma_wr = 4'b1000;
        #1;
        got7 = {bus_if.bus_ack, bus_if.dma_ack, bus_if.ram_ce_n, bus_if.ram_we_n};
        checks++;
        if (got7 !== 7'b0_0001_11) begin
            errors++;
            $display("FAIL iso_ch3_write_again: got %b expected %b", got7, 7'b0_0001_11);
        end
        tick();
        bus_if.dma_req = 4'b0000;
        #1;
        checks++;
        if (bus_if.dma_ack !== 4'b0001) begin
            errors++;
            $display("FAIL iso_release_cycle: got %b expected 0001", bus_if.dma_ack);
        end
        tick();
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b0_0000) begin
            errors++;
            $display("FAIL iso_turn: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b0_0000);
        end
        tick();
        bus_if.dma_wr = 4'b0000;
        checks++;
        if ({bus_if.bus_ack, bus_if.dma_ack} !== 5'b1_0000) begin
            errors++;
            $display("FAIL iso_idle: got %b expected %b", {bus_if.bus_ack, bus_if.dma_ack}, 5'b1_0000);
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_burst();
        test_reset_mid_burst();
        test_round_robin();
        test_short_grant();
        test_cpu_passthrough();
        test_ignore_other_strobes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
